// File: rtl/mpu_pkg.sv
// Shared constants and types for the MPU matrix memory and its host transfer port.
// A matrix word packs element k (row*5+col) at bits [8k +: 8].
package mpu_pkg;

   localparam int N_ELEM = 25;
   localparam int ELEM_W = 8;
   localparam int MAT_W  = N_ELEM * ELEM_W;
   localparam int ADDR_W = 3;
   localparam int RD_LAT = 2;
   localparam int CNT_W  = 5;
   localparam int LAT_W  = 2;

   localparam logic CMD_LOAD = 1'b1;
   localparam logic CMD_DUMP = 1'b0;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ELEM - 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      RD_WAIT,
      DUMP,
      DONE
   } state_e;

endpackage

// File: rtl/matrix_shift_reg.sv
// Matrix-wide register: parallel load of a stored word, then byte shifts toward
// bit 0 so the next element to stream out always sits in the low byte.
module matrix_shift_reg
   import mpu_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [MAT_W-1:0]  data_i,
   output logic [ELEM_W-1:0] byte_o
);

   logic [MAT_W-1:0] sr_q, sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load_i) begin
         sr_d = data_i;
      end else if (shift_i) begin
         sr_d = {{ELEM_W{1'b0}}, sr_q[MAT_W-1:ELEM_W]};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign byte_o = sr_q[ELEM_W-1:0];

endmodule

// File: rtl/matrix_transfer.sv
// Host byte-stream port into and out of the 200-bit matrix memory: a load packs
// 25 bytes into one word and writes it; a dump reads a word and streams its bytes.
module matrix_transfer
   import mpu_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ELEM_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ELEM_W-1:0] out_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wren,
   output logic [MAT_W-1:0]  mem_wdata,
   input  logic [MAT_W-1:0]  mem_rdata,
   output logic              busy,
   output logic              done
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [MAT_W-1:0]  wbuf_q, wbuf_d;
   logic [N_ELEM-1:0] lane_hit;
   logic              in_fire, out_fire;
   logic              sr_load, sr_shift;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_write == CMD_LOAD) begin
                  state_d = LOAD;
               end else if (cmd_write == CMD_DUMP) begin
                  state_d = RD_WAIT;
               end
            end
         end
         LOAD:    if (in_fire && cnt_q == CNT_LAST) state_d = WRITE;
         WRITE:   state_d = DONE;
         RD_WAIT: if (lat_q == LAT_LAST) state_d = DUMP;
         DUMP:    if (out_fire && cnt_q == CNT_LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // All handshake outputs decode registered state only, so ready/valid never
   // depend combinationally on the partner's valid/ready.
   always_comb begin
      cmd_ready = (state_q == IDLE);
      in_ready  = (state_q == LOAD);
      out_valid = (state_q == DUMP);
      mem_wren  = (state_q == WRITE);
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
   end

   for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_lane
      assign lane_hit[gi] = (cnt_q == CNT_W'(gi));
   end

   always_comb begin
      cnt_d    = cnt_q;
      lat_d    = lat_q;
      addr_d   = addr_q;
      wbuf_d   = wbuf_q;
      sr_load  = 1'b0;
      sr_shift = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d = cmd_addr;
               cnt_d  = '0;
               lat_d  = '0;
               wbuf_d = '0;
            end
         end
         LOAD: begin
            if (in_fire) begin
               for (int k = 0; k < N_ELEM; k++) begin
                  if (lane_hit[k]) wbuf_d[k*ELEM_W +: ELEM_W] = in_data;
               end
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RD_WAIT: begin
            // Address has been stable RD_LAT cycles; rdata is settled on this edge.
            lat_d = lat_q + LAT_W'(1);
            if (lat_q == LAT_LAST) sr_load = 1'b1;
         end
         DUMP: begin
            if (out_fire) begin
               sr_shift = 1'b1;
               cnt_d    = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         lat_q  <= '0;
         addr_q <= '0;
         wbuf_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         lat_q  <= lat_d;
         addr_q <= addr_d;
         wbuf_q <= wbuf_d;
      end
   end

   matrix_shift_reg u_shift (
      .clock   (clock),
      .reset_n (reset_n),
      .load_i  (sr_load),
      .shift_i (sr_shift),
      .data_i  (mem_rdata),
      .byte_o  (out_data)
   );

   assign mem_addr  = addr_q;
   assign mem_wdata = wbuf_q;

endmodule

// File: tb/tb_matrix_transfer.sv
// Self-checking bench for matrix_transfer: memory model with two-cycle read
// latency, scoreboards for memory writes and dumped bytes.
module tb_matrix_transfer;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         cmd_valid, cmd_ready, cmd_write;
   logic [2:0]   cmd_addr;
   logic         in_valid, in_ready;
   logic [7:0]   in_data;
   logic         out_valid, out_ready;
   logic [7:0]   out_data;
   logic [2:0]   mem_addr;
   logic         mem_wren;
   logic [199:0] mem_wdata;
   logic [199:0] mem_rdata;
   logic         busy, done;

   typedef struct {
      logic [2:0]   addr;
      logic [199:0] data;
   } wr_t;

   wr_t          exp_wr_q[$];
   logic [7:0]   exp_out_q[$];
   logic [199:0] mem_model[8];
   logic [199:0] rd_p1;
   int           checks = 0;
   int           errors = 0;

   always #5 clock = ~clock;

   matrix_transfer dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .mem_addr  (mem_addr),
      .mem_wren  (mem_wren),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      for (int a = 0; a < 8; a++) mem_model[a] = '0;
      for (int k = 0; k < 25; k++) mem_model[5][k*8 +: 8] = 8'hA0 + 8'(k);
   end

   always @(posedge clock) begin
      if (mem_wren) mem_model[mem_addr] <= mem_wdata;
      rd_p1     <= mem_model[mem_addr];
      mem_rdata <= rd_p1;
   end

   always @(negedge clock) begin
      if (reset_n && mem_wren) begin
         if (exp_wr_q.size() == 0) begin
            chk("unexpected_write", mem_addr, 3'd0 - 3'd1);
         end else begin
            wr_t e;
            e = exp_wr_q.pop_front();
            chk("wr_addr", mem_addr, e.addr);
            chk("wr_data", mem_wdata, e.data);
         end
      end
   end

   always @(negedge clock) begin
      if (reset_n && out_valid && out_ready) begin
         if (exp_out_q.size() == 0) begin
            chk("dump_extra_byte", 1'b1, 1'b0);
         end else begin
            logic [7:0] e;
            e = exp_out_q.pop_front();
            chk("dump_byte", out_data, e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic send_cmd(input logic wr, input logic [2:0] addr);
      int n = 0;
      @(posedge clock); #1;
      while (!cmd_ready && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      chk("cmd_ready_wait", cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      chk("in_ready_wait", in_ready, 1'b1);
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   task automatic do_load(input logic [2:0] addr, input logic [7:0] base,
                          input bit gaps, input bit extra, input bit abort_wr);
      wr_t e;
      e.addr = addr;
      for (int k = 0; k < 25; k++) e.data[k*8 +: 8] = base + 8'(k);
      if (!abort_wr) exp_wr_q.push_back(e);
      $display("load addr=%0d base=%0h gaps=%0d abort_in_write=%0d", addr, base, gaps, abort_wr);
      send_cmd(1'b1, addr);
      for (int i = 0; i < 25; i++) begin
         if (gaps && (i % 2 == 1)) begin
            in_valid = 1'b0;
            @(posedge clock); #1;
         end
         send_byte(base + 8'(i));
      end
      if (extra) begin
         in_valid = 1'b1;
         in_data  = 8'hEE;
      end
      chk("wren_after_last", mem_wren, 1'b1);
      chk("in_ready_in_write", in_ready, 1'b0);
      if (abort_wr) begin
         reset_n = 1'b0;
         #1;
         chk("wren_async_rst", mem_wren, 1'b0);
         @(posedge clock); #1;
         reset_n = 1'b1;
         chk("no_write_on_abort", mem_model[addr], 200'd0);
      end else begin
         @(posedge clock); #1;
         chk("done_pulse", done, 1'b1);
         chk("wren_one_cycle", mem_wren, 1'b0);
         chk("in_ready_in_done", in_ready, 1'b0);
         @(posedge clock); #1;
         chk("busy_after_done", busy, 1'b0);
         chk("done_cleared", done, 1'b0);
      end
      in_valid = 1'b0;
   endtask

   task automatic do_dump(input logic [2:0] addr, input logic [7:0] base, input int stall_at);
      int k = 0;
      int n = 0;
      bit stalled = 0;
      for (int i = 0; i < 25; i++) exp_out_q.push_back(base + 8'(i));
      $display("dump addr=%0d base=%0h stall_at=%0d", addr, base, stall_at);
      out_ready = 1'b1;
      send_cmd(1'b0, addr);
      while (k < 25 && n < 200) begin
         if (k == stall_at && !stalled && out_valid) begin
            out_ready = 1'b0;
            repeat (3) begin
               chk("bp_valid", out_valid, 1'b1);
               chk("bp_data", out_data, base + 8'(stall_at));
               @(posedge clock); #1;
            end
            stalled   = 1;
            out_ready = 1'b1;
         end
         if (out_valid && out_ready) k++;
         @(posedge clock); #1;
         n++;
      end
      chk("dump_count", k, 25);
      chk("dump_done", done, 1'b1);
      chk("dump_valid_off", out_valid, 1'b0);
      @(posedge clock); #1;
      chk("dump_idle", cmd_ready, 1'b1);
      chk("dump_q_drained", exp_out_q.size(), 0);
   endtask

   initial begin
      int n;
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #2;
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_wren", mem_wren, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_mem_addr", mem_addr, 3'd0);
      chk("rst_mem_wdata", mem_wdata, 200'd0);
      chk("rst_out_data", out_data, 8'd0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;

      do_load(3'd3, 8'h01, 0, 0, 0);
      do_load(3'd7, 8'h01, 1, 1, 0);
      do_dump(3'd5, 8'hA0, 10);
      do_dump(3'd3, 8'h01, 99);
      do_dump(3'd7, 8'h01, 99);

      $display("abort load addr=3 after 12 bytes");
      send_cmd(1'b1, 3'd3);
      for (int i = 0; i < 12; i++) send_byte(8'h55);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_cmd_ready", cmd_ready, 1'b1);
      chk("abort_busy", busy, 1'b0);
      chk("abort_in_ready", in_ready, 1'b0);
      chk("abort_mem_addr", mem_addr, 3'd0);
      chk("abort_wdata", mem_wdata, 200'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      do_load(3'd1, 8'h30, 0, 0, 0);
      do_dump(3'd3, 8'h01, 99);
      do_dump(3'd1, 8'h30, 99);

      $display("reset during dump addr=5");
      out_ready = 1'b0;
      send_cmd(1'b0, 3'd5);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      chk("rd_wait_reach_dump", out_valid, 1'b1);
      chk("first_dump_byte", out_data, 8'hA0);
      #2 reset_n = 1'b0;
      #1;
      chk("dump_rst_valid", out_valid, 1'b0);
      chk("dump_rst_data", out_data, 8'h00);
      @(posedge clock); #1;
      reset_n = 1'b1;

      do_load(3'd6, 8'h40, 0, 0, 1);

      repeat (3) @(posedge clock);
      #1;
      chk("wr_q_drained", exp_wr_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
